parity_serial_tx: RTL and testbench

//   Serial frame transmitter with a parity bit; the sending end of the parity-protected serial link.

---
 rtl/parity_serial_tx_if.sv | 21 ++
 rtl/parity_serial_tx.sv | 134 +++++++++++++
 tb/tb_parity_serial_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/parity_serial_tx_if.sv
// Parallel-word handshake and serial-line bundle for parity_serial_tx.
// The slave modport is the transmitter side; master is the local logic feeding it.
interface parity_serial_tx_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx_out;
   logic              busy;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_out, busy
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_out, busy
   );
endinterface

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start(0), DATA_W data bits LSB first, parity, stop(1).
// Odd parity by default; define TX_PARITY_EVEN_EN for even parity.
module parity_serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   parity_serial_tx_if.slave  s_if
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int IDX_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_shift;
   logic              r_parity;
   logic              r_tx_out;
   logic              r_ready;
   logic              r_busy;

   logic              w_accept;
   logic              w_parity;
   logic              w_bit_done;
   logic [DATA_W-1:0] w_shift_nxt;

   assign w_accept    = s_if.tx_valid && r_ready;
   assign w_bit_done  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_shift_nxt = r_shift >> 1;

`ifdef TX_PARITY_EVEN_EN
   assign w_parity = ^s_if.tx_data;
`else
   assign w_parity = ~^s_if.tx_data;
`endif

   // NOTE: state is updated only with non-blocking assignments so every branch
   // sees the pre-edge values of r_shift/r_cnt, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         // NOTE: the shift register is cleared too, so a frame abandoned by
         // reset leaves no stale data behind.
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx_out <= 1'b1;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state  <= S_START;
                  r_shift  <= s_if.tx_data;
                  r_parity <= w_parity;
                  r_tx_out <= 1'b0;
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
                  r_idx    <= '0;
               end
            end
            S_START: begin
               if (w_bit_done) begin
                  r_state  <= S_DATA;
                  r_cnt    <= '0;
                  r_tx_out <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (w_bit_done) begin
                  r_cnt <= '0;
                  if (r_idx == IDX_W'(DATA_W - 1)) begin
                     r_state  <= S_PARITY;
                     r_idx    <= '0;
                     r_tx_out <= r_parity;
                  end else begin
                     // Pre-load the next bit so tx_out changes exactly on the bit boundary.
                     r_shift  <= w_shift_nxt;
                     r_tx_out <= w_shift_nxt[0];
                     r_idx    <= r_idx + IDX_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_PARITY: begin
               if (w_bit_done) begin
                  r_state  <= S_STOP;
                  r_cnt    <= '0;
                  r_tx_out <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               if (w_bit_done) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_cnt    <= '0;
               r_idx    <= '0;
               r_tx_out <= 1'b1;
               r_ready  <= 1'b1;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign s_if.tx_ready = r_ready;
   assign s_if.tx_out   = r_tx_out;
   assign s_if.busy     = r_busy;
endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench for parity_serial_tx: words are queued on accept and
// compared against frames captured cycle by cycle from tx_out.
module tb_parity_serial_tx;
   localparam int DATA_W = 8;
   localparam int CPB    = 4;
   localparam int NBITS  = DATA_W + 3;
   localparam int FRAME  = NBITS * CPB;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   parity_serial_tx_if #(.DATA_W(DATA_W)) bus ();

   parity_serial_tx #(
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_if  (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference parity from a ones count, independent of the reduction operators.
   function automatic logic model_parity(input logic [DATA_W-1:0] d);
      int ones;
      ones = $countones(d);
`ifdef TX_PARITY_EVEN_EN
      return (ones % 2) == 1;
`else
      return (ones % 2) == 0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the first observation point after the accepting edge.
   task automatic send_word(input logic [DATA_W-1:0] d, input bit hold, output bit ok);
      ok = 1'b0;
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (bus.tx_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
         bus.tx_valid = 1'b0;
         return;
      end
      exp_q.push_back(d);
      tick();
      if (!hold) begin
         bus.tx_valid = 1'b0;
         bus.tx_data  = 'x;
      end
   endtask

   task automatic capture_frame();
      logic              s [FRAME];
      logic [DATA_W-1:0] exp_d;
      logic [DATA_W-1:0] got_d;
      int                busy_bad;
      int                ready_bad;
      int                unstable;
      busy_bad  = 0;
      ready_bad = 0;
      unstable  = 0;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      exp_d = exp_q.pop_front();
      for (int j = 0; j < FRAME; j++) begin
         s[j] = bus.tx_out;
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.tx_ready !== 1'b0) ready_bad++;
         if (j < FRAME - 1) tick();
      end
      for (int b = 0; b < NBITS; b++)
         for (int c = 1; c < CPB; c++)
            if (s[b*CPB+c] !== s[b*CPB]) unstable++;
      for (int i = 0; i < DATA_W; i++)
         got_d[i] = s[(1+i)*CPB + CPB/2];
      check($sformatf("start_%02h", exp_d), 32'(s[CPB/2]), 32'd0);
      check($sformatf("data_%02h", exp_d), 32'(got_d), 32'(exp_d));
      check($sformatf("parity_%02h", exp_d), 32'(s[(DATA_W+1)*CPB + CPB/2]), 32'(model_parity(exp_d)));
      check($sformatf("stop_%02h", exp_d), 32'(s[(DATA_W+2)*CPB + CPB/2]), 32'd1);
      check($sformatf("bit_stable_%02h", exp_d), 32'(unstable), 32'd0);
      check($sformatf("busy_cycles_%02h", exp_d), 32'(busy_bad), 32'd0);
      check($sformatf("ready_low_%02h", exp_d), 32'(ready_bad), 32'd0);
      tick();
      check($sformatf("post_tx_out_%02h", exp_d), 32'(bus.tx_out), 32'd1);
      check($sformatf("post_busy_%02h", exp_d), 32'(bus.busy), 32'd0);
      check($sformatf("post_ready_%02h", exp_d), 32'(bus.tx_ready), 32'd1);
   endtask

   initial begin
      bit ok;
      int bad;
      logic [DATA_W-1:0] rnd;

      // Reset held with tx_valid asserted: line idle, nothing accepted.
      bus.tx_data  = 8'hA5;
      bus.tx_valid = 1'b1;
      rst_n        = 1'b0;
      tick();
      check("rst_tx_out", 32'(bus.tx_out), 32'd1);
      check("rst_ready", 32'(bus.tx_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) bad++;
      end
      check("rst_hold_no_frame", 32'(bad), 32'd0);
      bus.tx_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_after_rst", {30'd0, bus.tx_out, bus.busy}, 32'b10);

      foreach (exp_q[i]) check("sb_stale", 32'd1, 32'd0);

      send_word(8'hA5, 1'b0, ok); capture_frame();
      send_word(8'h07, 1'b0, ok); capture_frame();
      send_word(8'h00, 1'b0, ok); capture_frame();

      // Back-to-back with tx_valid held; mid-frame data change must be ignored.
      send_word(8'h3C, 1'b1, ok);
      bus.tx_data = 8'hFF;
      capture_frame();
      send_word(8'hFF, 1'b0, ok);
      capture_frame();

      for (int k = 0; k < 3; k++) begin
         rnd = DATA_W'($urandom_range(0, 255));
         send_word(rnd, 1'b0, ok);
         capture_frame();
      end

      // Reset at cycle 20 of a frame (data bit 4 of 0x0F is low there).
      send_word(8'h0F, 1'b0, ok);
      for (int i = 0; i < 20; i++) tick();
      check("pre_reset_bit", 32'(bus.tx_out), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_tx_out", 32'(bus.tx_out), 32'd1);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_ready", 32'(bus.tx_ready), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
      tick();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 3 * CPB; i++) begin
         tick();
         if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) bad++;
      end
      check("no_resume", 32'(bad), 32'd0);
      send_word(8'h55, 1'b0, ok);
      capture_frame();

      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
